// File: rtl/rca_seq_ctrl.sv
// Multi-precision adder controller: two round-robin requesters share one SLICE-bit
// ripple-carry slice that walks a WIDTH-bit add LSB slice first, one slice per cycle.
module rca_seq_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id
);

  localparam int unsigned NSL = WIDTH / SLICE;
  localparam int unsigned IW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg;
  logic               carry_reg;
  logic [IW-1:0]      idx;
  logic               last_grant;

  logic               grant_c;
  logic               accept_c;
  logic               last_slice_c;
  logic [SLICE-1:0]   a_sl, b_sl, slice_sum;
  logic               slice_cout;

  // The only adder in the block: one SLICE-bit ripple slice fed from the current index.
  always_comb begin
    a_sl = a_reg[idx*SLICE +: SLICE];
    b_sl = b_reg[idx*SLICE +: SLICE];
    {slice_cout, slice_sum} = (SLICE+1)'(a_sl) + (SLICE+1)'(b_sl) + (SLICE+1)'(carry_reg);
  end

  // Next-state, round-robin grant and accept handshake.
  always_comb begin
    state_d      = state;
    grant_c      = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    accept_c     = 1'b0;
    last_slice_c = (idx == IW'(NSL - 1));
    case (state)
      IDLE: begin
        grant_c    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        req0_ready = req0_valid && !grant_c;
        req1_ready = req1_valid && grant_c;
        accept_c   = req0_ready || req1_ready;
        if (accept_c) state_d = RUN;
      end
      RUN:     if (last_slice_c) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Operand capture, per-slice sum/carry update and result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      carry_reg  <= 1'b0;
      idx        <= '0;
      last_grant <= 1'b1;
      res_valid  <= 1'b0;
      res_cout   <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            a_reg      <= grant_c ? req1_a : req0_a;
            b_reg      <= grant_c ? req1_b : req0_b;
            carry_reg  <= grant_c ? req1_cin : req0_cin;
            res_id     <= grant_c;
            last_grant <= grant_c;
            idx        <= '0;
          end
        end
        RUN: begin
          sum_reg[idx*SLICE +: SLICE] <= slice_sum;
          carry_reg <= slice_cout;
          idx       <= idx + 1'b1;
          if (last_slice_c) begin
            res_cout  <= slice_cout;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign res_sum = sum_reg;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: directed corner cases then random traffic, checked
// against plain WIDTH+1-bit arithmetic and a round-robin pointer model.
module tb_rca_seq_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SLICE = 4;
  localparam int unsigned NSL   = WIDTH / SLICE;

  logic             clk, rst;
  logic             req0_valid, req0_ready, req0_cin;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_cin;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             res_valid, res_ready, res_cout, res_id;
  logic [WIDTH-1:0] res_sum;

  rca_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit last_g = 1'b1;  // model of the arbitration pointer

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit cin);
    if (!id) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    else     begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
  endtask

  // Serve one operation; called at a negedge with request inputs already driven.
  task automatic run_one(input bit keep, input int hold);
    bit               g;
    logic [WIDTH-1:0] a, b;
    bit               c;
    logic [WIDTH:0]   exp;
    int               lat;
    #1;
    g = (req0_valid && req1_valid) ? ~last_g : req1_valid;
    check("req0_ready", 32'(req0_ready), 32'(!g));
    check("req1_ready", 32'(req1_ready), 32'(g));
    a   = g ? req1_a : req0_a;
    b   = g ? req1_b : req0_b;
    c   = g ? req1_cin : req0_cin;
    exp = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
    @(posedge clk);
    last_g = g;
    @(negedge clk);
    // operands after accept must not matter
    if (!keep) begin
      if (!g) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
    if (!g) begin req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_cin = ~req0_cin; end
    else    begin req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_cin = ~req1_cin; end
    res_ready = 1'b1;  // no result yet, must be ignored
    lat = 0;
    while (!res_valid && lat < 20) begin
      if (lat == 1) check("readies_run", 32'({req0_ready, req1_ready}), 32'(0));
      @(negedge clk);
      res_ready = 1'b0;
      lat++;
    end
    res_ready = 1'b0;
    check("latency", 32'(lat), 32'(NSL));
    check("res_sum", 32'(res_sum), 32'(exp[WIDTH-1:0]));
    check("res_cout", 32'(res_cout), 32'(exp[WIDTH]));
    check("res_id", 32'(res_id), 32'(g));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'(1));
      check("hold_sum", 32'({res_cout, res_sum}), 32'(exp));
      check("hold_id", 32'(res_id), 32'(g));
      check("hold_readies", 32'({req0_ready, req1_ready}), 32'(0));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_drop", 32'(res_valid), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    res_ready = 1'b0;
    #1;
    check("rst_valid", 32'(res_valid), 32'(0));
    check("rst_sum", 32'(res_sum), 32'(0));
    check("rst_cout_id", 32'({res_cout, res_id}), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_readies", 32'({req0_ready, req1_ready}), 32'(0));

    // directed cases
    set_req(1'b0, 16'h00F8, 16'h0003, 1'b1);
    run_one(1'b0, 0);
    set_req(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    run_one(1'b0, 0);
    set_req(1'b0, 16'h1234, 16'h1111, 1'b0);
    set_req(1'b1, 16'h8000, 16'h8000, 1'b0);
    run_one(1'b0, 0);
    run_one(1'b0, 0);

    // fairness with both held valid, backpressure on the first result
    set_req(1'b0, 16'h0F0F, 16'hF0F1, 1'b0);
    set_req(1'b1, 16'h7FFF, 16'h0000, 1'b1);
    run_one(1'b1, 6);
    for (int i = 0; i < 3; i++) run_one(1'b1, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // random traffic
    for (int n = 0; n < 24; n++) begin
      int unsigned v;
      v = $urandom_range(1, 3);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (v[0]) set_req(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      if (v[1]) set_req(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      run_one(1'($urandom), int'($urandom_range(0, 3)));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // async reset while RUN is at slice index 2
    set_req(1'b1, 16'hABCD, 16'h1357, 1'b1);
    #1;
    check("rst_test_ready", 32'(req1_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(res_valid), 32'(0));
    check("abort_sum", 32'(res_sum), 32'(0));
    check("abort_cout_id", 32'({res_cout, res_id}), 32'(0));
    last_g = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NSL + 2; i++) begin
      @(negedge clk);
      if (i == NSL + 1) check("abort_no_result", 32'(res_valid), 32'(0));
    end
    set_req(1'b0, 16'h0007, 16'h0009, 1'b0);
    set_req(1'b1, 16'h4444, 16'h2222, 1'b1);
    run_one(1'b0, 1);
    run_one(1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
